// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared execute-stage types for the multiplier and ALU decoder
package mips_pkg;

    // ALU decoder's alucontrol encoding that selects the multiply unit
    localparam logic [4:0] ALUCTL_MULT = 5'b10011;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        MTHI  = 2'b10,
        MTLO  = 2'b11
    } mult_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mult_state_t;

endpackage

// File: rtl/mult_signfix.sv
// rtl/mult_signfix.sv - operand magnitude and product sign correction
//
// Ports:
//   is_signed  : operands are two's complement (MULT)
//   a, b       : raw operands
//   neg        : product must be negated
//   prod       : unsigned magnitude product
//   a_mag      : |a| when signed, a otherwise
//   b_mag      : |b| when signed, b otherwise
//   result     : prod, or its two's-complement negation when neg is set
module mult_signfix #(
    parameter int WIDTH = 32
) (
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 neg,
    input  logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   result
);

    // Negating the most negative value yields 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    always_comb begin
        a_mag  = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag  = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        result = neg ? (~prod + (2*WIDTH)'(1)) : prod;
    end

endmodule

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative radix-2 shift-add multiplier with HI/LO registers
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : request strobe, only honoured in IDLE
//   op       : MULT / MULTU / MTHI / MTLO
//   srca     : multiplicand, or write data for MTHI/MTLO
//   srcb     : multiplier
//   busy     : high while a multiply is iterating
//   done     : one-cycle pulse after HI/LO commit
//   hi, lo   : architectural HI/LO registers
module mult_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  mult_op_t         op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mult_state_t        state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag, addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_step;
    logic [2*WIDTH-1:0] result;

    mult_signfix #(.WIDTH(WIDTH)) u_signfix (
        .is_signed (op == MULT),
        .a         (srca),
        .b         (srcb),
        .neg       (neg_q),
        .prod      (acc_step[2*WIDTH-1:0]),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .result    (result)
    );

    // One iteration: add into the upper half, carry lands in the spare MSB,
    // then the whole accumulator shifts right.
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = acc_q[2*WIDTH:WIDTH] + {1'b0, addend};
        acc_step = {sum, acc_q[WIDTH-1:0]} >> 1;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MULT, MULTU: begin
                            mcand_d  = a_mag;
                            mplier_d = b_mag;
                            acc_d    = '0;
                            cnt_d    = '0;
                            neg_d    = (op == MULT) && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                            state_d  = RUN;
                        end
                        MTHI:    hi_d = srca;
                        default: lo_d = srca;
                    endcase
                end
            end
            default: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    {hi_d, lo_d} = result;
                    state_d      = IDLE;
                    done_d       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative multi-cycle multiplier with architectural HI/LO registers.
- Sits beside the ALU in the execute stage and consumes the ALU decoder's mult decode (alucontrol 5'b10011) plus multu, mthi and mtlo decodes.
- Accepts two operands, runs radix-2 shift-add for WIDTH cycles, and commits the 2*WIDTH-bit product to HI/LO.
- Raises busy so the controller can stall mfhi/mflo and new multiplies.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits, HI = upper WIDTH, LO = lower WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only when state is IDLE.
- op  input  2  mult_op_t: MULT=2'b00 (signed), MULTU=2'b01, MTHI=2'b10, MTLO=2'b11.
- srca  input  WIDTH  multiplicand, or write data for MTHI/MTLO.
- srcb  input  WIDTH  multiplier; ignored for MTHI/MTLO.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle registered pulse on the cycle after HI/LO commit.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset_n low, any time, including mid-RUN):
  - state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0, accumulator=0.
  - Any in-flight product is discarded.
- States: IDLE, RUN. busy is decoded from state (RUN), not registered separately.
- IDLE, start=1, op=MULT or MULTU, at edge k:
  - Latch operand A into multiplicand and operand B into multiplier shift register.
  - Clear accumulator, counter=0, latch neg_flag, state->RUN.
- Operand formation:
  - MULT: operands are |srca| and |srcb|; neg_flag = srca[WIDTH-1] ^ srcb[WIDTH-1].
  - MULTU: raw operands; neg_flag = 0.
  - |x| of the most negative value is 2^(WIDTH-1) as an unsigned WIDTH-bit number. This is the correct magnitude; no overflow handling is needed.
- RUN, each edge:
  - If multiplier LSB = 1, add multiplicand into the upper half of a (2*WIDTH+1)-bit accumulator.
  - Shift the accumulator right 1 and the multiplier right 1.
  - counter++.
- RUN with counter=WIDTH-1 at edge k+WIDTH:
  - Final iteration completes.
  - {hi,lo} <= neg_flag ? two's-complement negation of the product : product.
  - state->IDLE, done<=1.
- Latency: start sampled at edge k; busy high after edges k..k+WIDTH-1; hi/lo valid and done=1 after edge k+WIDTH; busy=0 in that same cycle.
- done: asserted for exactly one cycle and cleared on the next edge.
- hi/lo hold their old values throughout RUN. They are never partially updated.
- start while RUN (any op, including MTHI/MTLO): ignored, no side effect. The controller must stall.
- Back-to-back: start in the done cycle is accepted, because state is IDLE.
- MTHI/MTLO in IDLE with start=1: hi (or lo) <= srca at that edge.
  - Single cycle; busy stays 0, done stays 0.
  - The other register is unchanged.
- start=0 in IDLE: no state change.
- Arithmetic: all adds are unsigned on WIDTH+1 bits; the carry shifts into the accumulator MSB. No flags or exceptions.

Decomposition:
- Shared package mips_pkg:
  - mult_op_t enum.
  - ALUCTL_MULT = 5'b10011 constant, shared with the ALU decoder.
  - state enum: IDLE, RUN.
- Optional sub-module mult_signfix (combinational): absolute value of the operands and conditional negation of the product. Everything else stays in mult_unit.

Test Plan:
- MULTU srca=32'hFFFF_FFFF, srcb=32'hFFFF_FFFF -> after 32 busy cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001, done pulses once.
- MULT srca=-3 (32'hFFFF_FFFD), srcb=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. MULT srca=32'h8000_0000, srcb=32'h8000_0000 -> hi=32'h4000_0000, lo=0.
- MTHI srca=32'h1234_5678, then MTLO srca=32'h9ABC_DEF0 -> hi/lo take those values one edge after each strobe; busy and done never assert.
- MULT 5×6 started; MTLO and a new MULT presented mid-RUN -> both ignored; hi=0, lo=30 at completion. A second MULT started in the done cycle is accepted, and busy rises at the next edge.
- reset_n pulsed low at iteration 10 of MULTU 100×200 -> immediate IDLE, hi=lo=0, busy=0, no done pulse. A subsequent MULTU 100×200 -> lo=20000.
- hi/lo stability: preload via MTHI/MTLO, start a MULT, and check that hi/lo stay unchanged every RUN cycle until commit.
